// File: rtl/ifmap_loader.sv
// Streams ifmap words into a shift-register scratchpad and slides a
// cfg_depth-word window along the row, cfg_stride words per slide.
module ifmap_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 12,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_depth,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [7:0]            cfg_num_windows,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  spad_w_en,
  output logic                  spad_shift,
  output logic [DATA_WIDTH-1:0] spad_din,
  output logic                  win_ready,
  input  logic                  win_done,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SETTLE = 3'd2,
    READY  = 3'd3,
    SHIFT  = 3'd4,
    REFILL = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]           LP_MEM_DEPTH = 32'(MEM_DEPTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_depth;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [7:0]            r_nwin;
  logic [7:0]            r_win_cnt;
  logic [ADDR_WIDTH-1:0] r_load_cnt;
  logic [ADDR_WIDTH-1:0] r_shift_cnt;
  logic                  r_w_en;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_shift;
  logic                  r_win_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_err;

  logic                  w_cfg_bad;
  logic                  w_loading;
  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_shift_last;
  logic [ADDR_WIDTH-1:0] w_load_target;
  logic [ADDR_WIDTH-1:0] w_shift_len;

  assign w_cfg_bad = (cfg_depth == {ADDR_WIDTH{1'b0}}) ||
                     (cfg_stride == {ADDR_WIDTH{1'b0}}) ||
                     (cfg_stride > cfg_depth) ||
                     (32'(cfg_depth) > LP_MEM_DEPTH) ||
                     (cfg_num_windows == 8'd0);

  // FILL loads a whole window, REFILL only the words freed by the last slide
  assign w_load_target = (r_state == REFILL) ? r_stride : r_depth;
  assign w_loading     = (r_state == FILL) || (r_state == REFILL);
  assign in_ready      = w_loading && (r_load_cnt != w_load_target);
  assign w_accept      = in_valid && in_ready;
  assign w_last_beat   = ((r_load_cnt + LP_ONE) == w_load_target);

  assign w_shift_len   = (r_state == DRAIN) ? r_depth : r_stride;
  assign w_shift_last  = (r_shift_cnt == (w_shift_len - LP_ONE));

  assign spad_w_en  = r_w_en;
  assign spad_din   = r_din;
  assign spad_shift = r_shift;
  assign win_ready  = r_win_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

  // Control FSM with registered outputs; each output flag changes on the transition edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_depth     <= {ADDR_WIDTH{1'b0}};
      r_stride    <= {ADDR_WIDTH{1'b0}};
      r_nwin      <= 8'd0;
      r_win_cnt   <= 8'd0;
      r_load_cnt  <= {ADDR_WIDTH{1'b0}};
      r_shift_cnt <= {ADDR_WIDTH{1'b0}};
      r_w_en      <= 1'b0;
      r_din       <= {DATA_WIDTH{1'b0}};
      r_shift     <= 1'b0;
      r_win_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_w_en    <= w_accept;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_accept) begin
        r_din <= in_data;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_depth    <= cfg_depth;
              r_stride   <= cfg_stride;
              r_nwin     <= cfg_num_windows;
              r_win_cnt  <= 8'd0;
              r_load_cnt <= {ADDR_WIDTH{1'b0}};
              r_busy     <= 1'b1;
              r_state    <= FILL;
            end
          end
        end
        FILL, REFILL: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_load_cnt <= {ADDR_WIDTH{1'b0}};
              r_state    <= SETTLE;
            end else begin
              r_load_cnt <= r_load_cnt + LP_ONE;
            end
          end
        end
        SETTLE: begin
          r_win_ready <= 1'b1;
          r_state     <= READY;
        end
        READY: begin
          if (win_done) begin
            r_win_ready <= 1'b0;
            r_shift     <= 1'b1;
            r_shift_cnt <= {ADDR_WIDTH{1'b0}};
            r_state     <= (r_win_cnt == (r_nwin - 8'd1)) ? DRAIN : SHIFT;
          end
        end
        SHIFT: begin
          if (w_shift_last) begin
            r_shift    <= 1'b0;
            r_win_cnt  <= r_win_cnt + 8'd1;
            r_load_cnt <= {ADDR_WIDTH{1'b0}};
            r_state    <= REFILL;
          end else begin
            r_shift_cnt <= r_shift_cnt + LP_ONE;
          end
        end
        DRAIN: begin
          if (w_shift_last) begin
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_shift_cnt <= r_shift_cnt + LP_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
